// File: rtl/song_pkg.sv
// Shared types and note-divider table for the melody sequencer.
package song_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_SOUND} state_t;

  // Score entry layout: [7:5] note code, [4] rest, [3:0] length in beats (0 = end)
  typedef struct packed {
    logic [2:0] note;
    logic       rest;
    logic [3:0] len;
  } entry_t;

  localparam logic [31:0] DO_DIV = 32'hBAA2;

  function automatic logic [31:0] note_div(input logic [2:0] code);
    case (code)
      3'd0: note_div = DO_DIV;
      3'd1: note_div = 32'hA646;
      3'd2: note_div = 32'h9422;
      3'd3: note_div = 32'h8BE8;
      3'd4: note_div = 32'h7CB8;
      3'd5: note_div = 32'h6EFA;
      3'd6: note_div = 32'h62F2;
      3'd7: note_div = 32'h5D5C;
    endcase
  endfunction

endpackage

// File: rtl/song_sequencer_ctrl_if.sv
// Control/status bundle between the host logic and the song sequencer.
interface song_sequencer_ctrl_if #(parameter int ADDR_W = 6);
  logic              play;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [31:0]       tone_divider;
  logic              sound_on;
  logic              busy;
  logic [ADDR_W-1:0] note_idx;
  logic              song_done;

  modport master (
    output play, stop, pause, loop_en,
    input  tone_divider, sound_on, busy, note_idx, song_done
  );

  modport slave (
    input  play, stop, pause, loop_en,
    output tone_divider, sound_on, busy, note_idx, song_done
  );
endinterface

// File: rtl/song_score_rom.sv
// Score ROM with registered output (1-cycle latency); contents come from the INIT image.
module song_score_rom #(
  parameter int                     SCORE_LEN = 64,
  parameter int                     ADDR_W    = 6,
  parameter logic [SCORE_LEN*8-1:0] INIT      = '0
) (
  input  logic            clk,
  input  logic [ADDR_W:0] addr,
  output logic [7:0]      data
);

  localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(SCORE_LEN);

  // Past the last entry the ROM reads as an end marker, never wrapping.
  always_ff @(posedge clk)
    data <= (addr < LEN) ? INIT[{addr[ADDR_W-1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: rtl/song_sequencer_ctrl.sv
// Steps the tone generator through a stored score: fetch, decode, then time each note in beats.
module song_sequencer_ctrl
  import song_pkg::*;
#(
  parameter int TICK_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 625_000,
  parameter int SCORE_LEN  = 64,
  parameter int ADDR_W     = $clog2(SCORE_LEN),
  parameter logic [SCORE_LEN*8-1:0] SCORE_INIT =
    {{(SCORE_LEN-8){8'h00}}, 8'hE2, 8'hC2, 8'hA2, 8'h82, 8'h62, 8'h42, 8'h22, 8'h02}
) (
  input logic                   CLK_50M,
  input logic                   reset,
  song_sequencer_ctrl_if.slave  bus
);

  localparam int              TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] GAP       = TICK_W'(GAP_CYCLES);
  localparam logic [ADDR_W:0]   END_ADDR  = (ADDR_W+1)'(SCORE_LEN);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   addr;
  logic [7:0]        rom_data;
  entry_t            ent;
  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        beats_left;
  logic              rest;
  logic [31:0]       tone;
  logic              done;
  logic              at_end, tick_zero, last_beat, counting;

  song_score_rom #(
    .SCORE_LEN (SCORE_LEN),
    .ADDR_W    (ADDR_W),
    .INIT      (SCORE_INIT)
  ) u_rom (
    .clk  (CLK_50M),
    .addr (addr),
    .data (rom_data)
  );

  assign ent       = entry_t'(rom_data);
  assign at_end    = (ent.len == 4'd0) || (addr >= END_ADDR);
  assign tick_zero = (tick_cnt == '0);
  assign last_beat = (beats_left == 4'd1);
  assign counting  = (state == S_SOUND) && !bus.pause;

  always_ff @(posedge CLK_50M) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.stop) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:   if (bus.play) state_nxt = S_FETCH;
        S_FETCH:  state_nxt = S_DECODE;
        S_DECODE: if (at_end) state_nxt = bus.loop_en ? S_FETCH : S_IDLE;
                  else        state_nxt = S_SOUND;
        S_SOUND:  if (counting && tick_zero && last_beat) state_nxt = S_FETCH;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      addr       <= '0;
      tick_cnt   <= '0;
      beats_left <= '0;
      rest       <= 1'b0;
      tone       <= DO_DIV;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.stop) addr <= '0;
      else begin
        case (state)
          S_IDLE: if (bus.play) addr <= '0;
          S_DECODE: begin
            if (at_end) begin
              addr <= '0;
              if (!bus.loop_en) done <= 1'b1;
            end else begin
              // Rests keep the previous pitch so the generator never sees a glitch.
              if (!ent.rest) tone <= note_div(ent.note);
              rest       <= ent.rest;
              beats_left <= ent.len;
              tick_cnt   <= TICK_LAST;
            end
          end
          S_SOUND: begin
            if (counting) begin
              if (!tick_zero)    tick_cnt <= tick_cnt - 1'b1;
              else if (last_beat) addr    <= addr + 1'b1;
              else begin
                beats_left <= beats_left - 1'b1;
                tick_cnt   <= TICK_LAST;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Articulation gap: the tail of the last beat is forced silent.
  always_comb begin
    bus.sound_on = (state == S_SOUND) && !rest && !bus.pause &&
                   !(last_beat && (tick_cnt < GAP));
    bus.busy     = (state != S_IDLE);
  end

  assign bus.tone_divider = tone;
  assign bus.note_idx     = addr[ADDR_W-1:0];
  assign bus.song_done    = done;

endmodule

// File: tb/tb_song_sequencer_ctrl.sv
// Scoreboarded bench: So(2) / rest(1) / Mi(1) / end, plus a second instance with no end marker.
module tb_song_sequencer_ctrl;

  localparam logic [31:0] DO = 32'hBAA2, MI = 32'h9422, SO = 32'h7CB8;
  localparam logic [64*8-1:0] SCORE1 = {{60{8'h00}}, 8'h00, 8'h41, 8'h11, 8'h82};
  localparam logic [64*8-1:0] SCORE2 = {64{8'h01}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pz  = 1'b0;
  logic lp  = 1'b0;
  int   errs = 0, checks = 0, cyc = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  song_sequencer_ctrl_if #(.ADDR_W(6)) bus  ();
  song_sequencer_ctrl_if #(.ADDR_W(6)) bus2 ();

  song_sequencer_ctrl #(.TICK_DIV(10), .GAP_CYCLES(3), .SCORE_LEN(64), .ADDR_W(6),
                        .SCORE_INIT(SCORE1))
    dut  (.CLK_50M(clk), .reset(rst), .bus(bus));

  song_sequencer_ctrl #(.TICK_DIV(10), .GAP_CYCLES(3), .SCORE_LEN(64), .ADDR_W(6),
                        .SCORE_INIT(SCORE2))
    dut2 (.CLK_50M(clk), .reset(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] got);
    int e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk(tag, got, e);
  endtask

  // One clock: drive just after the edge, return at the falling edge for sampling.
  task automatic cycle(input logic p = 1'b0, input logic s = 1'b0,
                       input logic r = 1'b0, input logic p2 = 1'b0);
    @(posedge clk); #1;
    bus.play = p; bus.stop = s; bus.pause = pz; bus.loop_en = lp;
    rst = r; bus2.play = p2;
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (!bus.sound_on && n < 50) begin cycle(); n++; end
  endtask

  task automatic count_lvl(input logic lvl, output int n);
    n = 0;
    while (bus.sound_on == lvl && n < 2000) begin n++; cycle(); end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 2000) begin cycle(); n++; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, t0, bad, seen, busy_low, rises, mx;
    logic prev;
    bus.play = 0; bus.stop = 0; bus.pause = 0; bus.loop_en = 0;
    bus2.play = 0; bus2.stop = 0; bus2.pause = 0; bus2.loop_en = 0;

    // Reset values
    push(DO); push(0); push(0); push(0); push(0);
    cycle(0, 0, 1); cycle(0, 0, 1); cycle();
    pop_chk("rst_div", bus.tone_divider);
    pop_chk("rst_sound", bus.sound_on);
    pop_chk("rst_busy", bus.busy);
    pop_chk("rst_idx", bus.note_idx);
    pop_chk("rst_done", bus.song_done);

    // Play and sequencing
    push(3); push(SO); push(0); push(1); push(17); push(17); push(MI); push(7);
    push(5); push(1); push(0);
    cycle(1);
    wait_rise(n);          pop_chk("play_rise", n);
    pop_chk("so_div", bus.tone_divider);
    pop_chk("so_idx", bus.note_idx);
    pop_chk("busy_run", bus.busy);
    count_lvl(1'b1, n);    pop_chk("so_on", n);
    count_lvl(1'b0, n);    pop_chk("so_to_mi_low", n);
    pop_chk("mi_div", bus.tone_divider);
    count_lvl(1'b1, n);    pop_chk("mi_on", n);
    wait_idle(n);          pop_chk("end_latency", n);
    pop_chk("done_pulse", bus.song_done);
    cycle();               pop_chk("done_once", bus.song_done);

    // Pause 25 cycles mid-So
    push(3); push(0); push(12); push(42); push(1);
    cycle(1);
    wait_rise(n);          pop_chk("pz_rise", n);
    t0 = cyc;
    repeat (4) cycle();
    pz = 1'b1; bad = 0;
    repeat (25) begin cycle(); if (bus.sound_on) bad++; end
    pop_chk("pz_silent", bad);
    pz = 1'b0;
    cycle();
    count_lvl(1'b1, n);    pop_chk("pz_remaining_on", n);
    pop_chk("pz_so_span", cyc - t0);
    wait_idle(n);          pop_chk("pz_done", bus.song_done);

    // Stop during Mi, then restart from entry 0
    push(0); push(0); push(0); push(0); push(0); push(0); push(3); push(SO); push(0);
    cycle(1);
    wait_rise(n); count_lvl(1'b1, n); count_lvl(1'b0, n);
    cycle(); cycle(0, 1); cycle();
    pop_chk("stop_busy", bus.busy);
    pop_chk("stop_sound", bus.sound_on);
    pop_chk("stop_idx", bus.note_idx);
    pop_chk("stop_done", bus.song_done);
    seen = 0; bad = 0;
    repeat (20) begin cycle(); if (bus.song_done) seen++; if (bus.busy) bad++; end
    pop_chk("stop_no_done", seen);
    pop_chk("stop_stays_idle", bad);
    cycle(1);
    wait_rise(n);          pop_chk("restart_rise", n);
    pop_chk("restart_div", bus.tone_divider);
    pop_chk("restart_idx", bus.note_idx);
    cycle(0, 1); cycle();

    // Loop at end marker
    push(7); push(0); push(0); push(SO); push(0);
    lp = 1'b1;
    cycle(1);
    wait_rise(n); count_lvl(1'b1, n); count_lvl(1'b0, n); count_lvl(1'b1, n);
    n = 0; seen = 0; busy_low = 0;
    while (!bus.sound_on && n < 100) begin
      n++;
      if (bus.song_done) seen++;
      if (!bus.busy) busy_low++;
      cycle();
    end
    pop_chk("loop_gap", n);
    pop_chk("loop_no_done", seen);
    pop_chk("loop_busy", busy_low);
    pop_chk("loop_div", bus.tone_divider);
    pop_chk("loop_idx", bus.note_idx);
    lp = 1'b0;
    cycle(0, 1); cycle();

    // Play while busy is ignored
    push(15); push(1);
    cycle(1);
    wait_rise(n); cycle(); cycle(1);
    count_lvl(1'b1, n);    pop_chk("busy_play_on", n);
    pop_chk("busy_play_busy", bus.busy);
    cycle(0, 1); cycle();

    // play + stop together from IDLE
    push(0); push(0);
    cycle(1, 1);
    seen = 0;
    repeat (6) begin cycle(); if (bus.busy || bus.sound_on) seen++; end
    pop_chk("playstop_busy", bus.busy);
    pop_chk("playstop_active", seen);

    // Synchronous reset mid-Mi
    push(DO); push(0); push(0); push(0); push(0); push(0);
    cycle(1);
    wait_rise(n); count_lvl(1'b1, n); count_lvl(1'b0, n);
    cycle(); cycle(0, 0, 1); cycle();
    pop_chk("mrst_div", bus.tone_divider);
    pop_chk("mrst_sound", bus.sound_on);
    pop_chk("mrst_busy", bus.busy);
    pop_chk("mrst_idx", bus.note_idx);
    pop_chk("mrst_done", bus.song_done);
    seen = 0;
    repeat (30) begin cycle(); if (bus.song_done || bus.busy) seen++; end
    pop_chk("mrst_quiet", seen);

    // Score without end marker: must stop after entry 63
    push(770); push(64); push(63); push(1);
    cycle(0, 0, 0, 1);
    n = 0; rises = 0; mx = 0; prev = 1'b0;
    while (n < 2000) begin
      cycle();
      if (!bus2.busy) break;
      n++;
      if (bus2.sound_on && !prev) rises++;
      prev = bus2.sound_on;
      if (bus2.sound_on && int'(bus2.note_idx) > mx) mx = int'(bus2.note_idx);
    end
    pop_chk("nomark_busy_len", n);
    pop_chk("nomark_notes", rises);
    pop_chk("nomark_last_idx", mx);
    pop_chk("nomark_done", bus2.song_done);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
